// File: rtl/stack_pkg.sv
// Shared definitions for the stack controller slice.
// Holds the command op codes, memory write codes, FSM state encoding
// and the default stack depth used as a parameter default.
package stack_pkg;

  localparam int DEPTH_BYTES_DEF = 256;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_PUSH  = 3'd1,
    OP_POP   = 3'd2,
    OP_CALL  = 3'd3,
    OP_RET   = 3'd4,
    OP_STORE = 3'd5,
    OP_LOAD  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  localparam logic [3:0] MEM_IDLE    = 4'h0;
  localparam logic [3:0] MEM_WR_ESP  = 4'h1;
  localparam logic [3:0] MEM_WR_ADDR = 4'h8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/stack_controller_if.sv
// Command/response handshake plus stack memory port of the stack controller.
//   cmd_*   : command from the execute stage (valid/ready).
//   rsp_*   : one-cycle response pulse, no back-pressure.
//   mem_*   : write code, address and data toward the stack memory, and the
//             two combinational read words coming back from it.
// master : the controller side; slave : execute stage + memory side.
interface stack_controller_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_data;
  logic [31:0] cmd_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [3:0]  mem_read_or_write;
  logic [31:0] mem_write_data;
  logic [31:0] mem_esp;
  logic [31:0] mem_stack_addr;
  logic [31:0] mem_stack_esp;
  logic [31:0] mem_stack_addr_access;

  modport master (
    input  cmd_valid, cmd_op, cmd_data, cmd_addr,
    input  mem_stack_esp, mem_stack_addr_access,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
    output mem_read_or_write, mem_write_data, mem_esp, mem_stack_addr
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_data, cmd_addr,
    output mem_stack_esp, mem_stack_addr_access,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
    input  mem_read_or_write, mem_write_data, mem_esp, mem_stack_addr
  );
endinterface

// File: rtl/stack_bounds.sv
// Combinational legality check for one stack command.
//   i_op   : command op code
//   i_esp  : current ESP
//   i_addr : absolute byte address (STORE/LOAD only)
//   o_err  : command must be rejected with no side effects
module stack_bounds
  import stack_pkg::*;
#(
  parameter int DEPTH_BYTES = DEPTH_BYTES_DEF,
  parameter int ESP_INIT    = DEPTH_BYTES
) (
  input  op_e         i_op,
  input  logic [31:0] i_esp,
  input  logic [31:0] i_addr,
  output logic        o_err
);

  localparam logic [31:0] ESP_EMPTY = 32'(ESP_INIT);
  localparam logic [31:0] ADDR_MAX  = 32'(DEPTH_BYTES - 4);

  always_comb begin
    o_err = 1'b0;
    case (i_op)
      OP_PUSH, OP_CALL:  o_err = (i_esp == 32'd0);
      OP_POP, OP_RET:    o_err = (i_esp == ESP_EMPTY);
      OP_STORE, OP_LOAD: o_err = (i_addr[1:0] != 2'b00) || (i_addr > ADDR_MAX);
      OP_RSVD:           o_err = 1'b1;
      default:           o_err = 1'b0;
    endcase
  end

endmodule

// File: rtl/stack_controller.sv
// Sequencing master for the CPU stack memory. Accepts one command every
// three cycles (IDLE -> EXEC -> RESP), owns ESP and drives the memory port.
//   clock, reset : clock and asynchronous active-low reset
//   bus          : command/response handshake and memory port (master)
//   esp          : architectural stack pointer
//   full, empty  : esp == 0 / esp == ESP_INIT
module stack_controller
  import stack_pkg::*;
#(
  parameter int DEPTH_BYTES = DEPTH_BYTES_DEF,
  parameter int ESP_INIT    = DEPTH_BYTES
) (
  input  logic                clock,
  input  logic                reset,
  stack_controller_if.master  bus,
  output logic [31:0]         esp,
  output logic                full,
  output logic                empty
);

  localparam logic [31:0] ESP_EMPTY = 32'(ESP_INIT);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [31:0] r_esp;
  op_e         r_op;
  logic        r_err;
  logic [31:0] r_data;
  logic [31:0] r_addr;
  logic [31:0] r_rsp_data;
  logic [31:0] w_rd_data;
  logic        w_err;
  logic        w_accept;
  op_e         w_op;

  assign w_op          = op_e'(bus.cmd_op);
  // Ready is also gated by reset so nothing is offered while reset is held.
  assign bus.cmd_ready = (r_state == ST_IDLE) && reset;
  assign w_accept      = bus.cmd_valid && bus.cmd_ready;

  assign bus.mem_esp = r_esp;
  assign esp         = r_esp;
  assign full        = (r_esp == 32'd0);
  assign empty       = (r_esp == ESP_EMPTY);

  stack_bounds #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .ESP_INIT    (ESP_INIT)
  ) u_bounds (
    .i_op   (w_op),
    .i_esp  (r_esp),
    .i_addr (bus.cmd_addr),
    .o_err  (w_err)
  );

  // Control state: FSM, ESP and the latched op/error flag.
  // PUSH/CALL pre-decrement at the accept edge so EXEC writes at the new ESP;
  // POP/RET read at the current ESP in EXEC and post-increment at its end.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_esp   <= ESP_EMPTY;
      r_op    <= OP_NOP;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op  <= w_op;
        r_err <= w_err;
        if (!w_err && (w_op == OP_PUSH || w_op == OP_CALL))
          r_esp <= r_esp - 32'd4;
      end else if (r_state == ST_EXEC && !r_err && (r_op == OP_POP || r_op == OP_RET)) begin
        r_esp <= r_esp + 32'd4;
      end
    end
  end

  // Datapath captures; outputs are gated by state, so these need no reset.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_data <= bus.cmd_data;
      r_addr <= bus.cmd_addr;
    end
    if (r_state == ST_EXEC)
      r_rsp_data <= w_rd_data;
  end

  always_comb begin
    w_state_nxt           = r_state;
    bus.mem_read_or_write = MEM_IDLE;
    bus.mem_write_data    = 32'd0;
    bus.mem_stack_addr    = 32'd0;
    w_rd_data             = 32'd0;
    bus.rsp_valid         = 1'b0;
    bus.rsp_err           = 1'b0;
    bus.rsp_data          = 32'd0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        w_state_nxt = ST_RESP;
        // A rejected command leaves the memory port idle and reads nothing.
        if (!r_err) begin
          case (r_op)
            OP_PUSH, OP_CALL: begin
              bus.mem_read_or_write = MEM_WR_ESP;
              bus.mem_write_data    = r_data;
            end
            OP_POP, OP_RET: begin
              w_rd_data = bus.mem_stack_esp;
            end
            OP_STORE: begin
              bus.mem_read_or_write = MEM_WR_ADDR;
              bus.mem_stack_addr    = r_addr;
              bus.mem_write_data    = r_data;
            end
            OP_LOAD: begin
              bus.mem_stack_addr = r_addr;
              w_rd_data          = bus.mem_stack_addr_access;
            end
            default: ;
          endcase
        end
      end
      ST_RESP: begin
        w_state_nxt   = ST_IDLE;
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = r_err;
        bus.rsp_data  = r_rsp_data;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_stack_controller.sv
module tb_stack_controller;
  import stack_pkg::*;

  localparam int DEPTH = 256;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [3:0]  code;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] esp;
  logic        full;
  logic        empty;

  stack_controller_if bus();

  stack_controller #(
    .DEPTH_BYTES (DEPTH),
    .ESP_INIT    (DEPTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .esp   (esp),
    .full  (full),
    .empty (empty)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  rsp_t rsp_q[$];
  wr_t  wr_q[$];

  // Reference model: the stack as a plain word array and an integer ESP.
  int          mdl_esp;
  logic [31:0] mdl_mem [DEPTH/4];

  // Memory attached to the DUT.
  logic [31:0] tmem [DEPTH/4];

  initial forever begin
    @(posedge clock);
    cyc <= cyc + 1;
  end

  always_comb begin
    bus.mem_stack_esp         = (bus.mem_esp < 32'(DEPTH)) ? tmem[bus.mem_esp[7:2]] : 32'h0;
    bus.mem_stack_addr_access = (bus.mem_stack_addr < 32'(DEPTH)) ? tmem[bus.mem_stack_addr[7:2]] : 32'h0;
  end

  initial begin
    for (int i = 0; i < DEPTH/4; i++) tmem[i] = 32'h0;
    forever begin
      @(posedge clock);
      if (reset) begin
        if (bus.mem_read_or_write == 4'h1 && bus.mem_esp < 32'(DEPTH))
          tmem[bus.mem_esp[7:2]] = bus.mem_write_data;
        else if (bus.mem_read_or_write == 4'h8 && bus.mem_stack_addr < 32'(DEPTH))
          tmem[bus.mem_stack_addr[7:2]] = bus.mem_write_data;
      end
    end
  end

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=absent required=present", nm);
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard.
  initial forever begin
    rsp_t r;
    wr_t  w;
    @(negedge clock);
    if (reset) begin
      if (bus.rsp_valid) begin
        if (rsp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rsp_unexpected actual=rsp_valid required=none");
        end else begin
          r = rsp_q.pop_front();
          chk32("rsp_data", bus.rsp_data, r.data);
          chk1("rsp_err", bus.rsp_err, r.err);
          chk32("rsp_cycle", 32'(cyc), 32'(r.cyc));
        end
      end else if (rsp_q.size() > 0 && cyc > rsp_q[0].cyc) begin
        fail_now("rsp_missing");
        void'(rsp_q.pop_front());
      end

      if (bus.mem_read_or_write != 4'h0) begin
        if (wr_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL wr_unexpected actual=%0h required=0", bus.mem_read_or_write);
        end else begin
          w = wr_q.pop_front();
          chk32("wr_code", 32'(bus.mem_read_or_write), 32'(w.code));
          chk32("wr_addr", (w.code == 4'h1) ? bus.mem_esp : bus.mem_stack_addr, w.addr);
          chk32("wr_data", bus.mem_write_data, w.data);
          chk32("wr_cycle", 32'(cyc), 32'(w.cyc));
        end
      end else if (wr_q.size() > 0 && cyc > wr_q[0].cyc) begin
        fail_now("wr_missing");
        void'(wr_q.pop_front());
      end
    end
  end

  task automatic wait_ready(output bit ok);
    int n = 0;
    @(negedge clock);
    while (!bus.cmd_ready && n < 10) begin
      @(negedge clock);
      n++;
    end
    ok = bus.cmd_ready;
    if (!ok) fail_now("accept_timeout");
  endtask

  task automatic issue(input int op, input logic [31:0] data, input logic [31:0] addr);
    bit          ok;
    bit          e;
    logic [31:0] rd;
    int          c0;
    wait_ready(ok);
    if (!ok) return;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'(op);
    bus.cmd_data  = data;
    bus.cmd_addr  = addr;
    c0 = cyc;
    case (op)
      1, 3:    e = (mdl_esp == 0);
      2, 4:    e = (mdl_esp == DEPTH);
      5, 6:    e = (addr % 4 != 0) || (addr > 32'(DEPTH - 4));
      7:       e = 1'b1;
      default: e = 1'b0;
    endcase
    rd = 32'h0;
    if (!e) begin
      case (op)
        1, 3: begin
          mdl_esp -= 4;
          mdl_mem[mdl_esp / 4] = data;
          wr_q.push_back('{4'h1, 32'(mdl_esp), data, c0 + 1});
        end
        2, 4: begin
          rd = mdl_mem[mdl_esp / 4];
          mdl_esp += 4;
        end
        5: begin
          mdl_mem[addr / 4] = data;
          wr_q.push_back('{4'h8, addr, data, c0 + 1});
        end
        6: rd = mdl_mem[addr / 4];
        default: ;
      endcase
    end
    rsp_q.push_back('{rd, e, c0 + 2});
    @(posedge clock);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'($urandom);
    bus.cmd_data  = $urandom;
    bus.cmd_addr  = $urandom;
  endtask

  task automatic check_arch(input string nm);
    repeat (2) @(negedge clock);
    chk32({nm, "_esp"}, esp, 32'(mdl_esp));
    chk1({nm, "_empty"}, empty, mdl_esp == DEPTH);
    chk1({nm, "_full"}, full, mdl_esp == 0);
    chk32({nm, "_mem_esp"}, bus.mem_esp, 32'(mdl_esp));
  endtask

  initial begin
    bit          ok;
    logic [31:0] a;
    int          op;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_data  = 32'h0;
    bus.cmd_addr  = 32'h0;
    mdl_esp = DEPTH;
    for (int i = 0; i < DEPTH/4; i++) mdl_mem[i] = 32'h0;

    repeat (3) @(negedge clock);
    chk1("rst_cmd_ready", bus.cmd_ready, 1'b0);
    chk1("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk1("rst_rsp_err", bus.rsp_err, 1'b0);
    chk32("rst_rsp_data", bus.rsp_data, 32'h0);
    chk32("rst_wr_code", 32'(bus.mem_read_or_write), 32'h0);
    chk32("rst_wr_data", bus.mem_write_data, 32'h0);
    chk32("rst_stack_addr", bus.mem_stack_addr, 32'h0);
    chk32("rst_esp", esp, 32'(DEPTH));
    chk1("rst_empty", empty, 1'b1);
    chk1("rst_full", full, 1'b0);
    reset = 1'b1;

    issue(1, 32'hDEAD_BEEF, 32'h0);
    chk32("push_esp", esp, 32'd252);
    check_arch("push");
    issue(2, 32'h0, 32'h0);
    check_arch("pop");
    issue(2, 32'h0, 32'h0);
    check_arch("pop_empty");

    for (int i = 0; i < 64; i++) issue((i % 2 == 0) ? 1 : 3, $urandom, 32'h0);
    check_arch("fill");
    issue(1, 32'hBAD0_0001, 32'h0);
    check_arch("overflow");
    for (int i = 0; i < 16; i++) issue((i % 2 == 0) ? 2 : 4, 32'h0, 32'h0);
    check_arch("unwind");

    issue(5, 32'h1234_5678, 32'd16);
    issue(6, 32'h0, 32'd16);
    issue(6, 32'h0, 32'd18);
    issue(6, 32'h0, 32'd254);
    issue(5, 32'h5555_AAAA, 32'd252);
    issue(6, 32'h0, 32'd252);
    issue(5, 32'h1, 32'd256);
    issue(7, 32'h77, 32'd0);
    issue(0, 32'h99, 32'd8);
    check_arch("misc");

    for (int i = 0; i < 150; i++) begin
      op = int'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) a = 32'($urandom_range(0, 63)) * 32'd4;
      else a = 32'($urandom_range(0, 300));
      issue(op, $urandom, a);
    end
    check_arch("random");

    // Reset during EXEC of a PUSH: write pulse cut, no response, ESP reloaded.
    repeat (3) @(negedge clock);
    wait_ready(ok);
    if (ok && mdl_esp > 0) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 3'd1;
      bus.cmd_data  = 32'hABCD_0123;
      bus.cmd_addr  = 32'h0;
      @(posedge clock);
      #1;
      bus.cmd_valid = 1'b0;
      chk32("abort_pre_code", 32'(bus.mem_read_or_write), 32'h1);
      chk32("abort_pre_esp", esp, 32'(mdl_esp - 4));
      #1 reset = 1'b0;
      #1;
      chk32("abort_code", 32'(bus.mem_read_or_write), 32'h0);
      chk32("abort_esp", esp, 32'(DEPTH));
      chk1("abort_ready", bus.cmd_ready, 1'b0);
      chk1("abort_rsp", bus.rsp_valid, 1'b0);
      mdl_esp = DEPTH;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      repeat (4) begin
        @(negedge clock);
        chk1("abort_no_rsp", bus.rsp_valid, 1'b0);
      end
      check_arch("abort");
    end

    issue(3, 32'h0000_4000, 32'h0);
    issue(4, 32'h0, 32'h0);
    check_arch("after_abort");

    repeat (5) @(negedge clock);
    chk32("rsp_q_drained", 32'(rsp_q.size()), 32'h0);
    chk32("wr_q_drained", 32'(wr_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stack_controller.md
# stack_controller

Sequencing master for the CPU stack memory. It accepts push, pop, call, ret, store and load commands from the execute stage over a valid/ready handshake. It owns the ESP register and drives the stack memory's write-code, address and data port, returning read data and an error flag as a response. It is the initiator end of the stack memory interface.

## Interface
Parameters:
- DEPTH_BYTES, 256: byte capacity of the stack memory; must be a multiple of 4.
- ESP_INIT, DEPTH_BYTES: ESP value after reset (empty stack).

Ports:
- clock  in  1  single clock for the whole block.
- reset  in  1  asynchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  3  0 NOP, 1 PUSH, 2 POP, 3 CALL, 4 RET, 5 STORE, 6 LOAD, 7 reserved.
- cmd_data  in  32  push/call/store data.
- cmd_addr  in  32  absolute byte address for STORE/LOAD.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_data  out  32  pop/ret/load data; 0 otherwise.
- rsp_err  out  1  command rejected, no side effects.
- mem_read_or_write  out  4  4'h0 idle, 4'h1 write at mem_esp, 4'h8 write at mem_stack_addr.
- mem_write_data  out  32  write data.
- mem_esp  out  32  current ESP to memory.
- mem_stack_addr  out  32  STORE/LOAD address.
- mem_stack_esp  in  32  memory word at mem_esp, combinational.
- mem_stack_addr_access  in  32  memory word at mem_stack_addr, combinational.
- esp  out  32  architectural ESP.
- full  out  1  esp == 0.
- empty  out  1  esp == ESP_INIT.

## Operation
- FSM states: IDLE, EXEC, RESP.
  - IDLE → EXEC on cmd_valid && cmd_ready.
  - EXEC → RESP always.
  - RESP → IDLE always.
- cmd_ready = 1 only in IDLE and not in reset.
- Accept cycle T: latch op, data, addr and the error check.
- Error conditions:
  - PUSH or CALL when full.
  - POP or RET when empty.
  - STORE or LOAD with addr[1:0] != 0 or addr > DEPTH_BYTES-4.
  - op 7.
- Error behaviour:
  - rsp_err = 1 and rsp_data = 0.
  - ESP is unchanged.
  - mem_read_or_write stays 4'h0.
- PUSH/CALL:
  - At the T edge, esp ← esp-4.
  - In EXEC, mem_read_or_write = 4'h1, mem_write_data = cmd_data, mem_esp = new esp.
  - CALL is identical to PUSH; the return address is carried in cmd_data.
- POP/RET:
  - In EXEC, capture mem_stack_esp into rsp_data.
  - At the end of EXEC, esp ← esp+4.
- STORE: in EXEC, mem_read_or_write = 4'h8, mem_stack_addr = addr, mem_write_data = cmd_data.
- LOAD: in EXEC, mem_stack_addr = addr; capture mem_stack_addr_access.
- NOP: no memory activity; response issued with rsp_err = 0.
- Arithmetic: ESP is 32-bit. Bounds checks prevent wraparound, so ESP stays within [0, ESP_INIT], word aligned.

## Timing
- Reset values (asserted asynchronously):
  - State IDLE, esp = ESP_INIT, empty = 1, full = 0.
  - cmd_ready = 0 while reset is low.
  - rsp_valid = 0, rsp_err = 0, rsp_data = 0.
  - mem_read_or_write = 4'h0, mem_write_data = 0, mem_stack_addr = 0.
- Fixed latency: rsp_valid at cycle T+2 for every accepted command, including errors.
- Throughput: one command per 3 cycles.
- Memory write code is asserted for exactly the EXEC cycle; all other cycles are 4'h0.
- rsp_valid has no back-pressure; the consumer must take it in that cycle.
- cmd_* inputs are ignored outside the accept cycle.
- Reset mid-operation (EXEC or RESP):
  - Immediate return to IDLE.
  - Write code forced to 4'h0, pending response dropped.
  - ESP reloaded to ESP_INIT; memory contents untouched.
- mem_esp always equals esp, combinationally.

## Structure
- Shared package stack_pkg holds:
  - cmd op codes;
  - memory write codes 4'h0, 4'h1, 4'h8;
  - FSM state encoding;
  - the default DEPTH_BYTES.
- Optional sub-module stack_bounds: a combinational error check taking (op, esp, addr) and producing err. It keeps the FSM file small and can be unit-tested alone.

## Test plan
- Reset, then PUSH 32'hDEAD_BEEF → write code 4'h1 at mem_esp = 252 for one cycle; esp = 252; rsp_valid at T+2 with rsp_err = 0.
- Continuing from the PUSH, POP → rsp_data = 32'hDEAD_BEEF, esp = 256, empty = 1.
- POP with an empty stack → rsp_err = 1, esp stays 256, no write code.
- 64 PUSHes → full = 1, esp = 0; a 65th PUSH gives rsp_err = 1 with no write.
- STORE 32'h1234_5678 at addr 16, then LOAD 16 → code 4'h8 at addr 16; rsp_data = 32'h1234_5678.
- LOAD at addr 18 and at addr 254 → both give rsp_err = 1.
- Reset asserted during EXEC of a PUSH → write code drops to 0 that cycle; no rsp_valid; esp = 256.
